mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cvp14_pkg.sv | 18 +
 rtl/rr_arb2.sv | 32 +++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvp14_pkg.sv
// Shared types and defaults for the memory arbiter: FSM state encoding,
// 16-bit word/address types and default latency/burst limits.
package cvp14_pkg;

  typedef logic [15:0] word_t;
  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_NEXT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int MEM_LAT_DEF   = 1;
  localparam int BURST_MAX_DEF = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 = fetch, bit 1 = vector; on a tie the
// requester that was not granted last wins. Reset leaves "vector" as last grant.
module rr_arb2
  import cvp14_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  logic r_last_v;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last_v ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_last_v <= 1'b1;
    else if (i_take && (o_gnt != 2'b00))
      r_last_v <= o_gnt[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one DRAM port between an instruction fetch unit and a vector unit.
// Define ARB_BURST_EN to honour vLen bursts; otherwise every vector access is one word.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | arbitrate fetch/vector requests, latch address/dir/length
// ST_ACCESS | drive Addr and RD or WR for MEM_LAT cycles of one word
// ST_NEXT   | advance address, count down remaining words
// ST_DONE   | vDone pulse for vector bursts, release grant
module mem_arbiter
  import cvp14_pkg::*;
#(
  parameter int MEM_LAT   = MEM_LAT_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic        Clk1,
  input  logic        Reset_l,
  input  logic        fReq,
  input  logic [15:0] fAddr,
  output logic        fGnt,
  output logic [15:0] fData,
  output logic        fValid,
  input  logic        vReq,
  input  logic        vWr,
  input  logic [15:0] vAddr,
  input  logic [4:0]  vLen,
  input  logic [15:0] vWData,
  output logic        vWAck,
  output logic [15:0] vRData,
  output logic        vValid,
  output logic        vGnt,
  output logic        vDone,
  output logic [15:0] Addr,
  output logic        RD,
  output logic        WR,
  output logic [15:0] MemOut,
  input  logic [15:0] MemIn
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  state_t           r_state;
  addr_t            r_addr;
  word_t            r_fdata;
  word_t            r_vrdata;
  logic             r_fvalid;
  logic             r_vvalid;
  logic             r_fgnt;
  logic             r_vgnt;
  logic             r_own_v;
  logic             r_wr;
  logic [CNT_W-1:0] r_cnt;
  logic [LAT_W-1:0] r_lat;

  logic [CNT_W-1:0] w_vlen;
  logic [1:0]       w_gnt;
  logic             w_take;
  logic             w_access;
  logic             w_last;

`ifdef ARB_BURST_EN
  always_comb begin
    w_vlen = CNT_W'(vLen);
    if (vLen == 5'd0)
      w_vlen = CNT_W'(1);
    else if (int'(vLen) > BURST_MAX)
      w_vlen = CNT_W'(BURST_MAX);
  end
`else
  logic w_unused_vlen;
  assign w_unused_vlen = ^vLen;
  assign w_vlen        = CNT_W'(1);
`endif

  assign w_take   = (r_state == ST_IDLE);
  assign w_access = (r_state == ST_ACCESS);
  assign w_last   = (r_lat == '0);

  rr_arb2 u_rr_arb2 (
    .i_clk   (Clk1),
    .i_rst_n (Reset_l),
    .i_req   ({vReq, fReq}),
    .i_take  (w_take),
    .o_gnt   (w_gnt)
  );

  always_ff @(posedge Clk1 or negedge Reset_l) begin
    if (!Reset_l) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_fdata  <= '0;
      r_vrdata <= '0;
      r_fvalid <= 1'b0;
      r_vvalid <= 1'b0;
      r_fgnt   <= 1'b0;
      r_vgnt   <= 1'b0;
      r_own_v  <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= '0;
      r_lat    <= '0;
    end else begin
      r_fvalid <= 1'b0;
      r_vvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_lat <= LAT_LOAD;
          if (w_gnt[0]) begin
            r_fgnt  <= 1'b1;
            r_own_v <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= fAddr;
            r_cnt   <= CNT_W'(1);
            r_state <= ST_ACCESS;
          end else if (w_gnt[1]) begin
            r_vgnt  <= 1'b1;
            r_own_v <= 1'b1;
            r_wr    <= vWr;
            r_addr  <= vAddr;
            r_cnt   <= w_vlen;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (w_last) begin
            if (!r_wr) begin
              if (r_own_v) begin
                r_vrdata <= MemIn;
                r_vvalid <= 1'b1;
              end else begin
                r_fdata  <= MemIn;
                r_fvalid <= 1'b1;
              end
            end
            r_state <= ST_NEXT;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        ST_NEXT: begin
          r_addr  <= r_addr + 16'd1;
          r_cnt   <= r_cnt - 1'b1;
          r_lat   <= LAT_LOAD;
          r_state <= (r_cnt == CNT_W'(1)) ? ST_DONE : ST_ACCESS;
        end
        ST_DONE: begin
          r_fgnt  <= 1'b0;
          r_vgnt  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode from the registered state so reset removes them at once.
  assign RD     = w_access && !r_wr;
  assign WR     = w_access && r_wr;
  assign MemOut = (w_access && r_wr) ? vWData : 16'h0000;
  assign vWAck  = w_access && r_wr && w_last;
  assign vDone  = (r_state == ST_DONE) && r_own_v;
  assign Addr   = r_addr;
  assign fGnt   = r_fgnt;
  assign vGnt   = r_vgnt;
  assign fData  = r_fdata;
  assign fValid = r_fvalid;
  assign vRData = r_vrdata;
  assign vValid = r_vvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: dut 0 runs MEM_LAT=1, dut 1 runs MEM_LAT=2,
// each against its own DRAM model. Expectations follow ARB_BURST_EN.
module tb_mem_arbiter;

`ifdef ARB_BURST_EN
  localparam int BURST = 1;
`else
  localparam int BURST = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [2];
  logic        fReq   [2];
  logic [15:0] fAddr  [2];
  logic        fGnt   [2];
  logic [15:0] fData  [2];
  logic        fValid [2];
  logic        vReq   [2];
  logic        vWr    [2];
  logic [15:0] vAddr  [2];
  logic [4:0]  vLen   [2];
  logic [15:0] vWData [2];
  logic        vWAck  [2];
  logic [15:0] vRData [2];
  logic        vValid [2];
  logic        vGnt   [2];
  logic        vDone  [2];
  logic [15:0] Addr   [2];
  logic        RD     [2];
  logic        WR     [2];
  logic [15:0] MemOut [2];
  logic [15:0] MemIn  [2];

  logic [15:0] mem [2][65536];

  int n_tests = 0;
  int n_fail  = 0;

  int n_rd   [2] = '{0, 0};
  int n_wr   [2] = '{0, 0};
  int n_fv   [2] = '{0, 0};
  int n_vv   [2] = '{0, 0};
  int n_vd   [2] = '{0, 0};
  int n_wack [2] = '{0, 0};
  int n_viol [2] = '{0, 0};
  logic [15:0] f_last [2];
  logic [15:0] rd_log [256];
  logic [15:0] vv_log [256];

  mem_arbiter #(.MEM_LAT(1), .BURST_MAX(16)) u_dut1 (
    .Clk1(clk), .Reset_l(rst_n[0]),
    .fReq(fReq[0]), .fAddr(fAddr[0]), .fGnt(fGnt[0]), .fData(fData[0]), .fValid(fValid[0]),
    .vReq(vReq[0]), .vWr(vWr[0]), .vAddr(vAddr[0]), .vLen(vLen[0]), .vWData(vWData[0]),
    .vWAck(vWAck[0]), .vRData(vRData[0]), .vValid(vValid[0]), .vGnt(vGnt[0]), .vDone(vDone[0]),
    .Addr(Addr[0]), .RD(RD[0]), .WR(WR[0]), .MemOut(MemOut[0]), .MemIn(MemIn[0])
  );

  mem_arbiter #(.MEM_LAT(2), .BURST_MAX(16)) u_dut2 (
    .Clk1(clk), .Reset_l(rst_n[1]),
    .fReq(fReq[1]), .fAddr(fAddr[1]), .fGnt(fGnt[1]), .fData(fData[1]), .fValid(fValid[1]),
    .vReq(vReq[1]), .vWr(vWr[1]), .vAddr(vAddr[1]), .vLen(vLen[1]), .vWData(vWData[1]),
    .vWAck(vWAck[1]), .vRData(vRData[1]), .vValid(vValid[1]), .vGnt(vGnt[1]), .vDone(vDone[1]),
    .Addr(Addr[1]), .RD(RD[1]), .WR(WR[1]), .MemOut(MemOut[1]), .MemIn(MemIn[1])
  );

  assign MemIn[0] = mem[0][Addr[0]];
  assign MemIn[1] = mem[1][Addr[1]];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (WR[i]) mem[i][Addr[i]] <= MemOut[i];
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (RD[i]) begin
        if (i == 0) rd_log[n_rd[0] & 255] = Addr[0];
        n_rd[i]++;
      end
      if (WR[i]) n_wr[i]++;
      if (vWAck[i]) n_wack[i]++;
      if (fValid[i]) begin
        f_last[i] = fData[i];
        n_fv[i]++;
      end
      if (vValid[i]) begin
        if (i == 0) vv_log[n_vv[0] & 255] = vRData[0];
        n_vv[i]++;
      end
      if (vDone[i]) n_vd[i]++;
      if ((fGnt[i] && vGnt[i]) || (RD[i] && WR[i])) n_viol[i]++;
    end
  end

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic go(input int i, input logic f, input logic v,
                    output logic gf, output logic gv, output int lat);
    int c;
    fReq[i] = f;
    vReq[i] = v;
    c = 0;
    while (c < 20 && !(fGnt[i] || vGnt[i])) begin
      @(posedge clk); #1;
      c++;
    end
    lat = c;
    gf  = fGnt[i];
    gv  = vGnt[i];
    fReq[i] = 1'b0;
    vReq[i] = 1'b0;
    if (!(gf || gv)) check("grant_timeout", 0, 1);
    c = 0;
    while (c < 300 && (fGnt[i] || vGnt[i])) begin
      @(posedge clk); #1;
      c++;
    end
    if (fGnt[i] || vGnt[i]) check("release_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic vload(input string tag, input logic [15:0] base, input logic [4:0] len,
                       input int exp_n);
    int s_rd, s_vv, s_vd, lat;
    logic gf, gv;
    logic [15:0] a;
    vAddr[0] = base;
    vLen[0]  = len;
    vWr[0]   = 1'b0;
    s_rd = n_rd[0];
    s_vv = n_vv[0];
    s_vd = n_vd[0];
    go(0, 1'b0, 1'b1, gf, gv, lat);
    check({tag, "_gnt"}, {30'd0, gf, gv}, 32'b01);
    check({tag, "_rd_cycles"}, n_rd[0] - s_rd, exp_n);
    check({tag, "_vvalid"}, n_vv[0] - s_vv, exp_n);
    check({tag, "_vdone"}, n_vd[0] - s_vd, 1);
    for (int k = 0; k < exp_n; k++) begin
      a = base + 16'(k);
      check({tag, "_addr"}, rd_log[(s_rd + k) & 255], a);
      check({tag, "_data"}, vv_log[(s_vv + k) & 255], pat(a));
    end
  endtask

  initial begin
    logic gf, gv, rd_before;
    int lat, s_rd, s_fv, s_vd, s_wr, s_wack, k, c;
    logic [15:0] wd [3];
    logic ack_prev;

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; fReq[i] = 1'b0; fAddr[i] = 16'h0; vReq[i] = 1'b0;
      vWr[i] = 1'b0; vAddr[i] = 16'h0; vLen[i] = 5'd0; vWData[i] = 16'h0;
    end
    for (int a = 0; a < 65536; a++) begin
      mem[0][a] <= pat(16'(a));
      mem[1][a] <= 16'h0000;
    end
    mem[0][16'h0010] <= 16'hABCD;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_addr", Addr[i], 0);
      check("rst_rdata", {fData[i], vRData[i]}, 0);
      check("rst_ctl", {MemOut[i], fGnt[i], vGnt[i], RD[i], WR[i],
                        fValid[i], vValid[i], vDone[i], vWAck[i]}, 0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;

    // round robin after reset: fetch, vector, fetch
    fAddr[0] = 16'h0010;
    vAddr[0] = 16'h0600;
    vLen[0]  = 5'd1;
    go(0, 1'b1, 1'b1, gf, gv, lat);
    check("arb_tie1", {30'd0, gf, gv}, 32'b10);
    check("gnt_latency", lat, 1);
    go(0, 1'b1, 1'b1, gf, gv, lat);
    check("arb_tie2", {30'd0, gf, gv}, 32'b01);
    go(0, 1'b1, 1'b1, gf, gv, lat);
    check("arb_tie3", {30'd0, gf, gv}, 32'b10);

    // single fetch
    s_rd = n_rd[0];
    s_fv = n_fv[0];
    go(0, 1'b1, 1'b0, gf, gv, lat);
    check("fetch_gnt", {30'd0, gf, gv}, 32'b10);
    check("fetch_rd_cycles", n_rd[0] - s_rd, 1);
    check("fetch_addr", rd_log[s_rd & 255], 16'h0010);
    check("fetch_fvalid", n_fv[0] - s_fv, 1);
    check("fetch_data", f_last[0], 16'hABCD);
    check("fetch_gnt_drop", {fGnt[0], vGnt[0]}, 0);

    vload("load_wrap", 16'hFFFE, 5'd4, BURST ? 4 : 1);
    vload("load_len8", 16'h0200, 5'd8, BURST ? 8 : 1);
    vload("load_len0", 16'h0500, 5'd0, 1);
    vload("load_len20", 16'h0400, 5'd20, BURST ? 16 : 1);

    // reset in the middle of an 8-word load
    vAddr[0] = 16'h0300;
    vLen[0]  = 5'd8;
    s_vd = n_vd[0];
    vReq[0] = 1'b1;
    c = 0;
    while (c < 50 && !RD[0]) begin
      @(negedge clk);
      c++;
    end
    check("midrst_first_rd", RD[0], 1);
    vReq[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rd_before = RD[0];
    rst_n[0] = 1'b0;
    #1;
    check("midrst_rd_before", rd_before, BURST ? 1 : 0);
    check("midrst_drop", {RD[0], WR[0], vGnt[0], vValid[0], vDone[0]}, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_vdone", n_vd[0] - s_vd, BURST ? 0 : 1);
    s_rd = n_rd[0];
    s_fv = n_fv[0];
    go(0, 1'b1, 1'b0, gf, gv, lat);
    check("postrst_gnt", {30'd0, gf, gv}, 32'b10);
    check("postrst_addr", rd_log[s_rd & 255], 16'h0010);
    check("postrst_fvalid", n_fv[0] - s_fv, 1);
    check("postrst_data", f_last[0], 16'hABCD);

    // 3-word store on the MEM_LAT=2 instance
    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333;
    vAddr[1]  = 16'h0100;
    vLen[1]   = 5'd3;
    vWr[1]    = 1'b1;
    vWData[1] = wd[0];
    s_wr   = n_wr[1];
    s_wack = n_wack[1];
    s_vd   = n_vd[1];
    s_rd   = n_rd[1];
    k = 0;
    ack_prev = 1'b0;
    fork
      go(1, 1'b0, 1'b1, gf, gv, lat);
      begin
        for (int cc = 0; cc < 100 && k < (BURST ? 3 : 1); cc++) begin
          @(posedge clk); #1;
          if (ack_prev) begin
            k++;
            if (k < 3) vWData[1] = wd[k];
          end
          ack_prev = vWAck[1];
        end
      end
    join
    check("store_gnt", {30'd0, gf, gv}, 32'b01);
    check("store_wr_cycles", n_wr[1] - s_wr, BURST ? 6 : 2);
    check("store_wack", n_wack[1] - s_wack, BURST ? 3 : 1);
    check("store_vdone", n_vd[1] - s_vd, 1);
    check("store_no_rd", n_rd[1] - s_rd, 0);
    check("store_mem100", mem[1][16'h0100], 16'h1111);
    check("store_mem101", mem[1][16'h0101], BURST ? 16'h2222 : 16'h0000);
    check("store_mem102", mem[1][16'h0102], BURST ? 16'h3333 : 16'h0000);
    check("store_mem103", mem[1][16'h0103], 16'h0000);

    check("protocol_viol", n_viol[0] + n_viol[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
